// File: rtl/key_note_controller.sv
// Keyboard front end: synchronises and debounces raw keys, resolves held keys to a
// single note (lowest-index or last-pressed priority), tracks octave, emits note events.
module key_note_controller #(
  parameter int NUM_KEYS        = 7,
  parameter int NOTE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_raw,
  input  logic                mode,
  input  logic                octave_up,
  input  logic                octave_down,
  output logic [NOTE_W-1:0]   note_out,
  output logic [NUM_KEYS-1:0] led_out,
  output logic [1:0]          octave_out,
  output logic                note_valid,
  output logic                note_on,
  output logic                note_off
);

  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_reg;
  logic [NUM_KEYS-1:0] sync2_reg;
  logic [NUM_KEYS-1:0] stable_reg;
  logic [NUM_KEYS-1:0] stable_next;
  logic [NUM_KEYS-1:0] rise;
  logic [IDX_W-1:0]    last_reg;
  logic [IDX_W-1:0]    last_next;

  logic [IDX_W-1:0]    lowest_idx;
  logic                any_pressed;
  logic [IDX_W-1:0]    sel_idx;
  logic [NOTE_W-1:0]   sel_note;
  logic [NUM_KEYS-1:0] sel_led;

  logic [1:0]          oct_reg;
  logic [1:0]          oct_next;
  logic [NOTE_W-1:0]   note_reg;
  logic [NUM_KEYS-1:0] led_reg;
  logic                valid_reg;
  logic                on_reg;
  logic                off_reg;
  logic                on_next;
  logic                off_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= keys_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Per-key debounce: count consecutive cycles the synchronised level disagrees
  // with the accepted state; accept it once the run reaches DEBOUNCE_CYCLES.
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             bit_next;

      always_comb begin
        cnt_next = '0;
        bit_next = stable_reg[gi];
        if (sync2_reg[gi] != stable_reg[gi]) begin
          if (cnt_reg == CNT_LAST) begin
            bit_next = ~stable_reg[gi];
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign stable_next[gi] = bit_next;
    end
  endgenerate

  assign rise = stable_next & ~stable_reg;

  // Simultaneous rising edges resolve to the lowest index.
  always_comb begin
    last_next = last_reg;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (rise[i]) begin
        last_next = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_reg <= '0;
      last_reg   <= '0;
    end else begin
      stable_reg <= stable_next;
      last_reg   <= last_next;
    end
  end

  always_comb begin
    lowest_idx  = '0;
    any_pressed = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (stable_reg[i]) begin
        lowest_idx  = IDX_W'(i);
        any_pressed = 1'b1;
      end
    end
  end

  always_comb begin
    sel_idx  = lowest_idx;
    sel_note = '0;
    sel_led  = '0;
    if (mode && stable_reg[last_reg]) begin
      sel_idx = last_reg;
    end
    if (any_pressed) begin
      sel_note         = NOTE_W'(sel_idx) + NOTE_W'(1);
      sel_led[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    oct_next = oct_reg;
    if (octave_up && !octave_down && (oct_reg != 2'd2)) begin
      oct_next = oct_reg + 2'd1;
    end else if (octave_down && !octave_up && (oct_reg != 2'd0)) begin
      oct_next = oct_reg - 2'd1;
    end
  end

  // Events compare the new selection against what is currently on the outputs.
  always_comb begin
    on_next  = (sel_note != '0) && ((sel_note != note_reg) || (oct_next != oct_reg));
    off_next = (sel_note == '0) && (note_reg != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oct_reg   <= 2'd1;
      note_reg  <= '0;
      led_reg   <= '0;
      valid_reg <= 1'b0;
      on_reg    <= 1'b0;
      off_reg   <= 1'b0;
    end else begin
      oct_reg   <= oct_next;
      note_reg  <= sel_note;
      led_reg   <= sel_led;
      valid_reg <= (sel_note != '0);
      on_reg    <= on_next;
      off_reg   <= off_next;
    end
  end

  assign note_out   = note_reg;
  assign led_out    = led_reg;
  assign octave_out = oct_reg;
  assign note_valid = valid_reg;
  assign note_on    = on_reg;
  assign note_off   = off_reg;

endmodule

// File: tb/tb_key_note_controller.sv
// Scoreboard bench for key_note_controller: a window-based reference model predicts
// every output cycle; a negedge monitor compares the DUT against the predictions.
module tb_key_note_controller;

  localparam int NK = 7;
  localparam int NW = 4;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] keys_raw = '0;
  logic          mode = 1'b0;
  logic          octave_up = 1'b0;
  logic          octave_down = 1'b0;
  logic [NW-1:0] note_out;
  logic [NK-1:0] led_out;
  logic [1:0]    octave_out;
  logic          note_valid;
  logic          note_on;
  logic          note_off;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_note_controller #(
    .NUM_KEYS(NK), .NOTE_W(NW), .DEBOUNCE_CYCLES(D), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .keys_raw(keys_raw), .mode(mode),
    .octave_up(octave_up), .octave_down(octave_down),
    .note_out(note_out), .led_out(led_out), .octave_out(octave_out),
    .note_valid(note_valid), .note_on(note_on), .note_off(note_off)
  );

  typedef struct {
    logic [NW-1:0] note;
    logic [NK-1:0] led;
    logic [1:0]    oct;
    logic          valid;
    logic          on;
    logic          off;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: hist[j] holds raw keys sampled j+1 edges ago; a key's accepted
  // state flips when the D samples that have passed the 2-flop synchroniser all disagree.
  logic [NK-1:0] hist [0:D];
  logic [NK-1:0] m_stable;
  logic [NK-1:0] new_stable;
  int            m_last = 0;
  int            m_note = 0;
  int            m_oct = 1;
  int            sel;
  int            new_note;
  int            new_oct;
  bit            all_diff;
  exp_t          pe;

  always @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j <= D; j++) hist[j] = '0;
      m_stable = '0;
      m_last   = 0;
      m_note   = 0;
      m_oct    = 1;
      pe.note = '0; pe.led = '0; pe.oct = 2'd1; pe.valid = 1'b0; pe.on = 1'b0; pe.off = 1'b0;
      exp_q.push_back(pe);
    end else begin
      sel = -1;
      if (mode && m_stable[m_last]) sel = m_last;
      else for (int k = NK - 1; k >= 0; k--) if (m_stable[k]) sel = k;
      new_note = sel + 1;
      new_oct = m_oct;
      if (octave_up && !octave_down && m_oct < 2) new_oct = m_oct + 1;
      if (octave_down && !octave_up && m_oct > 0) new_oct = m_oct - 1;
      pe.note  = NW'(new_note);
      pe.led   = (sel >= 0) ? NK'(1 << sel) : '0;
      pe.oct   = 2'(new_oct);
      pe.valid = (new_note != 0);
      pe.on    = (new_note != 0) && (new_note != m_note || new_oct != m_oct);
      pe.off   = (new_note == 0) && (m_note != 0);
      exp_q.push_back(pe);
      m_note = new_note;
      m_oct  = new_oct;

      new_stable = m_stable;
      for (int k = 0; k < NK; k++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= D; j++) if (hist[j][k] == m_stable[k]) all_diff = 1'b0;
        if (all_diff) new_stable[k] = ~m_stable[k];
      end
      for (int k = NK - 1; k >= 0; k--) if (new_stable[k] && !m_stable[k]) m_last = k;
      m_stable = new_stable;
      for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = keys_raw;
    end
  end

  exp_t me;
  always @(negedge clk) begin
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t no prediction for DUT output", $time);
    end else begin
      me = exp_q.pop_front();
      if (note_out !== me.note || led_out !== me.led || octave_out !== me.oct ||
          note_valid !== me.valid || note_on !== me.on || note_off !== me.off) begin
        errors++;
        $display("FAIL outputs t=%0t got note=%0d led=%b oct=%0d valid=%b on=%b off=%b exp note=%0d led=%b oct=%0d valid=%b on=%b off=%b",
                 $time, note_out, led_out, octave_out, note_valid, note_on, note_off,
                 me.note, me.led, me.oct, me.valid, me.on, me.off);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dcheck(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d exp %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    keys_raw = 7'h7F;
    rst = 1'b1;
    cyc(2);
    dcheck("reset_note", int'(note_out), 0);
    dcheck("reset_oct", int'(octave_out), 1);
    rst = 1'b0;
    cyc(6);
    dcheck("t1_before_latency", int'(note_out), 0);
    cyc(1);
    dcheck("t1_note", int'(note_out), 1);
    dcheck("t1_note_on", int'(note_on), 1);
    cyc(1);
    dcheck("t1_on_single", int'(note_on), 0);

    keys_raw = '0;
    cyc(10);
    keys_raw = 7'b0000100;
    cyc(7);
    dcheck("t2_note", int'(note_out), 3);
    dcheck("t2_led", int'(led_out), 4);
    keys_raw = '0;
    cyc(7);
    dcheck("t2_note_off", int'(note_off), 1);
    cyc(3);

    for (int r = 0; r < 5; r++) begin
      keys_raw = 7'b0000001;
      cyc(3);
      keys_raw = '0;
      cyc(4);
    end
    dcheck("t3_glitch_silent", int'(note_out), 0);

    mode = 1'b0;
    keys_raw = 7'b0010000;
    cyc(10);
    keys_raw = 7'b0010010;
    cyc(10);
    dcheck("t4_lowest", int'(note_out), 2);
    keys_raw = 7'b0010000;
    cyc(10);
    dcheck("t4_fallback", int'(note_out), 5);

    mode = 1'b1;
    keys_raw = 7'b0000010;
    cyc(10);
    keys_raw = 7'b0010010;
    cyc(10);
    dcheck("t5_last_pressed", int'(note_out), 5);
    keys_raw = 7'b0000010;
    cyc(10);
    dcheck("t5_fallback", int'(note_out), 2);
    keys_raw = 7'b1000010;
    cyc(10);
    dcheck("t5_key6", int'(note_out), 7);
    mode = 1'b0;
    cyc(1);
    dcheck("t5_mode_switch", int'(note_out), 2);

    keys_raw = 7'b0001000;
    cyc(10);
    for (int r = 0; r < 3; r++) begin
      octave_up = 1'b1;
      cyc(1);
      octave_up = 1'b0;
      cyc(2);
    end
    dcheck("t6_oct_sat", int'(octave_out), 2);
    octave_up = 1'b1;
    octave_down = 1'b1;
    cyc(1);
    octave_up = 1'b0;
    octave_down = 1'b0;
    cyc(1);
    dcheck("t6_both_hold", int'(octave_out), 2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    dcheck("t6_rst_no_off", int'(note_off), 0);
    cyc(7);
    dcheck("t6_return", int'(note_out), 4);

    for (int it = 0; it < 2000; it++) begin
      if ($urandom_range(0, 5) == 0) keys_raw[$urandom_range(0, NK - 1)] ^= 1'b1;
      octave_up   = ($urandom_range(0, 15) == 0);
      octave_down = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) mode = ~mode;
      rst = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    rst = 1'b0;
    octave_up = 1'b0;
    octave_down = 1'b0;
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
